// File: rtl/clock_frequency_divider_pkg.sv
// Shared constants and helpers for the board clock dividers.
// Holds the board reference frequency and the counter-width helper.
package clock_frequency_divider_pkg;

    localparam int BOARD_CLK_HZ = 32'sd50_000_000;

    // Counter width able to hold 0..half-1, never narrower than one bit.
    function automatic int cnt_width(input int half);
        int w;
        w = 32'sd1;
        if (half > 32'sd1) begin
            w = $clog2(half);
        end else begin
            w = 32'sd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/clock_frequency_divider.sv
// Divides InClock down to a 50 % duty-cycle OutClock by toggling a single
// flop every HALF source edges.
module clock_frequency_divider
    import clock_frequency_divider_pkg::*;
#(
    parameter int INPUT_FREQUENCY  = BOARD_CLK_HZ,
    parameter int OUTPUT_FREQUENCY = 32'sd1
) (
    input  logic InClock,
    input  logic resetApp,
    output logic OutClock
);

    // Guarded so an illegal parameter set reaches the fatal checks below
    // instead of tripping a divide-by-zero while elaborating.
    localparam int HALF = ((OUTPUT_FREQUENCY > 32'sd0) && (INPUT_FREQUENCY > 32'sd0))
                        ? (INPUT_FREQUENCY / (32'sd2 * OUTPUT_FREQUENCY))
                        : 32'sd0;
    localparam int CNT_W = cnt_width(HALF);
    localparam logic [CNT_W-1:0] TERM = (HALF > 32'sd0) ? CNT_W'(HALF - 32'sd1)
                                                        : {CNT_W{1'b0}};

    if (OUTPUT_FREQUENCY <= 32'sd0) begin : g_bad_output_freq
        $fatal(1, "clock_frequency_divider: OUTPUT_FREQUENCY must be positive");
    end
    if (INPUT_FREQUENCY <= 32'sd0) begin : g_bad_input_freq
        $fatal(1, "clock_frequency_divider: INPUT_FREQUENCY must be positive");
    end
    if ((OUTPUT_FREQUENCY > 32'sd0) && (INPUT_FREQUENCY > 32'sd0) && (HALF == 32'sd0))
    begin : g_bad_ratio
        $fatal(1, "clock_frequency_divider: OUTPUT_FREQUENCY exceeds INPUT_FREQUENCY/2");
    end

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             out_q;
    logic             out_d;

    // Next-state: wrap and toggle on the terminal count, otherwise count up.
    always_comb begin
        cnt_d = cnt_q;
        out_d = out_q;
        if (cnt_q == TERM) begin
            cnt_d = {CNT_W{1'b0}};
            out_d = ~out_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            out_d = out_q;
        end
    end

    // State registers, cleared asynchronously by resetApp.
    always_ff @(posedge InClock or posedge resetApp) begin
        if (resetApp) begin
            cnt_q <= {CNT_W{1'b0}};
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign OutClock = out_q;

endmodule

// File: tb/tb_clock_frequency_divider.sv
// Directed bench for clock_frequency_divider at HALF=5, HALF=1 and
// HALF=1-by-truncation, sharing one source clock and one reset.
module tb_clock_frequency_divider;

    logic in_clock;
    logic reset_app;
    logic out_h5;
    logic out_h1;
    logic out_h1t;

    int n_checks;
    int n_pass;

    clock_frequency_divider #(
        .INPUT_FREQUENCY (100),
        .OUTPUT_FREQUENCY(10)
    ) u_dut_h5 (
        .InClock (in_clock),
        .resetApp(reset_app),
        .OutClock(out_h5)
    );

    clock_frequency_divider #(
        .INPUT_FREQUENCY (100),
        .OUTPUT_FREQUENCY(50)
    ) u_dut_h1 (
        .InClock (in_clock),
        .resetApp(reset_app),
        .OutClock(out_h1)
    );

    clock_frequency_divider #(
        .INPUT_FREQUENCY (100),
        .OUTPUT_FREQUENCY(30)
    ) u_dut_h1t (
        .InClock (in_clock),
        .resetApp(reset_app),
        .OutClock(out_h1t)
    );

    initial begin
        in_clock = 1'b0;
        forever #5 in_clock = ~in_clock;
    end

    task automatic check_value(input string tag, input int obs, input int exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            n_pass = n_pass + 1;
        end
    endtask

    initial begin
        int rise_edges[$];
        int prev;
        int first_rise;
        int exp_h5;
        int exp_h1;

        n_checks  = 0;
        n_pass    = 0;
        reset_app = 1'b1;

        // Held in reset across clock edges, all outputs stay low.
        repeat (3) @(negedge in_clock);
        check_value("reset_h5",  int'(out_h5),  0);
        check_value("reset_h1",  int'(out_h1),  0);
        check_value("reset_h1t", int'(out_h1t), 0);

        // Release between edges; the next rising edge is edge 1.
        reset_app = 1'b0;
        prev = 0;
        for (int n = 1; n <= 105; n++) begin
            @(negedge in_clock);
            exp_h5 = (n / 5) % 2;
            exp_h1 = n % 2;
            check_value($sformatf("h5_edge%0d", n),  int'(out_h5),  exp_h5);
            check_value($sformatf("h1_edge%0d", n),  int'(out_h1),  exp_h1);
            check_value($sformatf("h1t_edge%0d", n), int'(out_h1t), exp_h1);
            if ((prev == 0) && (out_h5 === 1'b1)) begin
                rise_edges.push_back(n);
            end
            prev = int'(out_h5);
        end

        check_value("h5_rise_count", rise_edges.size(), 11);
        if (rise_edges.size() > 0) begin
            check_value("h5_first_rise", rise_edges[0], 5);
        end else begin
            check_value("h5_first_rise", 0, 5);
        end
        for (int i = 1; i < rise_edges.size(); i++) begin
            check_value($sformatf("h5_period%0d", i), rise_edges[i] - rise_edges[i-1], 10);
        end

        // Fresh run: after 8 edges OutClock is high and the counter is at 3.
        reset_app = 1'b1;
        @(negedge in_clock);
        reset_app = 1'b0;
        repeat (8) @(negedge in_clock);
        check_value("h5_high_before_pulse", int'(out_h5), 1);

        // Asynchronous clear with no clock edge in between.
        #2;
        reset_app = 1'b1;
        #1;
        check_value("h5_async_clear", int'(out_h5), 0);
        @(negedge in_clock);
        check_value("h5_held_in_reset", int'(out_h5), 0);
        check_value("h1_held_in_reset", int'(out_h1), 0);
        reset_app = 1'b0;

        first_rise = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge in_clock);
            if ((first_rise == 0) && (out_h5 === 1'b1)) begin
                first_rise = k;
            end
        end
        check_value("h5_rise_after_pulse", first_rise, 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
